// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_e    : transmitter FSM state encoding
//   calc_bit_div  : clocks per serial bit (integer-truncated CLK_FREQ/BAUD)
//   DATA_BITS     : payload bits per frame
//   IDLE_LEVEL    : line level while idle and during stop bits
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } tx_state_e;

  function automatic int calc_bit_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Bundle between the transmitter and its environment (FIFO read side and
// serial/status outputs).
//   fifo_dout   : FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : one-cycle FIFO read strobe
//   txd         : serial line, idle high
//   busy        : transmitter not idle
//   tx_done     : one-cycle pulse after the last stop bit
//   frame_count : completed frames, wraps at 16 bits
// master = transmitter side, slave = FIFO / observer side.
interface fifo_uart_tx_if;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        txd;
  logic        busy;
  logic        tx_done;
  logic [15:0] frame_count;

  modport master (
    input  fifo_dout, fifo_empty,
    output fifo_rd_en, txd, busy, tx_done, frame_count
  );

  modport slave (
    output fifo_dout, fifo_empty,
    input  fifo_rd_en, txd, busy, tx_done, frame_count
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_DIV-1 while enabled and wraps to 0.
//   clk   : clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear to 0 (takes priority over en)
//   en    : count enable
//   tick  : high in the last cycle of a bit period (wrap cycle)
module uart_baud_gen #(
  parameter  int BIT_DIV = 16,
  localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(BIT_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a standard-mode (non-FWFT) FIFO.
// Frames are 8 data bits, LSB first, with 1 or 2 stop bits.
//   uart_tx_clk : clock, all logic on the rising edge
//   reset       : asynchronous active-low reset
//   bus         : fifo_uart_tx_if master (FIFO read port + serial/status outputs)
//
// state   | meaning
// S_IDLE  | line high; issue a FIFO read when data is available
// S_READ  | wait one cycle for FIFO read latency
// S_LOAD  | capture fifo_dout into the shift register, clear bit timer
// S_START | start bit (low) for one bit period
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit(s) high; pulse tx_done and count the frame at the end
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int STOP_BITS = 1
) (
  input  logic           uart_tx_clk,
  input  logic           reset,
  fifo_uart_tx_if.master bus
);

  localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);

  if (BIT_DIV < 2) begin : g_bit_div_chk
    $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_bits_chk
    $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        stop_idx_q;
  logic        txd_q;
  logic        rd_en_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] frame_cnt_q;

  logic        baud_clr;
  logic        baud_en;
  logic        baud_tick;

  assign baud_clr = (state_q == S_LOAD);
  assign baud_en  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

  uart_baud_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_baud_gen (
    .clk   (uart_tx_clk),
    .reset (reset),
    .clr   (baud_clr),
    .en    (baud_en),
    .tick  (baud_tick)
  );

  always_ff @(posedge uart_tx_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      txd_q       <= IDLE_LEVEL;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q <= IDLE_LEVEL;
          if (!bus.fifo_empty) begin
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          shift_q    <= bus.fifo_dout;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          txd_q      <= ~IDLE_LEVEL;
          state_q    <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
              txd_q     <= IDLE_LEVEL;
              state_q   <= S_STOP;
            end else begin
              // shift_q[1] is the bit that becomes shift_q[0] after this shift
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          txd_q   <= IDLE_LEVEL;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en  = rd_en_q;
  assign bus.txd         = txd_q;
  assign bus.busy        = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// dut0 uses one stop bit, dut1 two stop bits. Each has a behavioural FIFO.
// The reference model works on a frame timeline: once the transmitter is idle
// and the FIFO is non-empty, the read strobe comes next cycle (offset 0), the
// start bit spans offsets 2..17, data bit i spans 18+16i..33+16i, stop bits
// follow, and tx_done / the frame count update at offset 146+16*stop_bits.
// A line decoder independently recovers bytes and inter-frame gaps.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_uart_tx_if bus0 ();
  fifo_uart_tx_if bus1 ();

  fifo_uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(1)) dut (
    .uart_tx_clk (clk),
    .reset       (rst_n),
    .bus         (bus0)
  );

  fifo_uart_tx #(.CLK_FREQ(16), .BAUD(1), .STOP_BITS(2)) dut2 (
    .uart_tx_clk (clk),
    .reset       (rst_n),
    .bus         (bus1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  // behavioural standard-mode FIFOs
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];

  always @(posedge clk) begin
    logic rd0, rd1;
    rd0 = bus0.fifo_rd_en;
    rd1 = bus1.fifo_rd_en;
    #1;
    if (rd0 && fq0.size() > 0) bus0.fifo_dout = fq0.pop_front();
    if (rd1 && fq1.size() > 0) bus1.fifo_dout = fq1.pop_front();
    bus0.fifo_empty = (fq0.size() == 0);
    bus1.fifo_empty = (fq1.size() == 0);
  end

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) begin
      fq0.push_back(b); mq0.push_back(b); bus0.fifo_empty = 1'b0;
    end else begin
      fq1.push_back(b); mq1.push_back(b); bus1.fifo_empty = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // observed values per DUT
  logic        o_txd[2], o_rd[2], o_busy[2], o_done[2], o_empty[2];
  logic [15:0] o_fc[2];

  // model state
  int          sb[2] = '{1, 2};
  bit          m_act[2];
  int          m_anchor[2];
  logic [7:0]  m_byte[2];
  logic [15:0] m_fc[2];

  // decoder / monitors
  bit          dec_act[2];
  int          dec_t0[2];
  logic [7:0]  dec_sh[2];
  int          last_t0[2] = '{-1, -1};
  logic        prev_txd[2] = '{1'b1, 1'b1};
  int          rise_cyc[2];
  int          done_gap[2];
  int          rd_cnt[2], done_cnt[2], busy_cnt[2], low_cnt[2];
  logic [7:0]  rx0[$];
  logic [7:0]  rx1[$];
  int          gq[$];

  task automatic decode(input int d);
    int off, i;
    if (!rst_n) begin
      dec_act[d] = 0; last_t0[d] = -1;
    end else begin
      if (!dec_act[d] && prev_txd[d] && !o_txd[d]) begin
        dec_act[d] = 1; dec_t0[d] = cyc;
        if (d == 0 && last_t0[d] >= 0) gq.push_back(cyc - last_t0[d] - (144 + 16 * sb[d]));
        last_t0[d] = cyc;
      end else if (dec_act[d]) begin
        off = cyc - dec_t0[d];
        if (off >= 24 && (off - 8) % 16 == 0) begin
          i = (off - 8) / 16;
          if (i <= 8) dec_sh[d][i-1] = o_txd[d];
          else begin
            chk($sformatf("stop_bit[%0d]", d), o_txd[d], 1'b1);
            if (d == 0) rx0.push_back(dec_sh[d]); else rx1.push_back(dec_sh[d]);
            dec_act[d] = 0;
          end
        end
      end
      if (!prev_txd[d] && o_txd[d]) rise_cyc[d] = cyc;
      if (o_done[d]) done_gap[d] = cyc - rise_cyc[d];
    end
    prev_txd[d] = o_txd[d];
    rd_cnt[d]   += int'(o_rd[d]);
    done_cnt[d] += int'(o_done[d]);
    busy_cnt[d] += int'(o_busy[d]);
    low_cnt[d]  += int'(!o_txd[d]);
  endtask

  task automatic step(input int d);
    int k, endk;
    logic e_txd, e_rd, e_busy, e_done;
    endk = 146 + 16 * sb[d];
    e_txd = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!rst_n) begin
      m_act[d] = 0; m_fc[d] = '0;
    end else begin
      if (m_act[d] && (cyc - m_anchor[d]) == endk) begin
        m_act[d] = 0; m_fc[d] = m_fc[d] + 16'd1; e_done = 1'b1;
      end
      if (m_act[d]) begin
        k = cyc - m_anchor[d];
        e_busy = 1'b1;
        e_rd   = (k == 0);
        if (k >= 2 && k < 18) e_txd = 1'b0;
        else if (k >= 18 && k < 146) e_txd = m_byte[d][(k - 18) / 16];
      end
    end
    chk($sformatf("txd[%0d]", d),         o_txd[d],  e_txd);
    chk($sformatf("fifo_rd_en[%0d]", d),  o_rd[d],   e_rd);
    chk($sformatf("busy[%0d]", d),        o_busy[d], e_busy);
    chk($sformatf("tx_done[%0d]", d),     o_done[d], e_done);
    chk($sformatf("frame_count[%0d]", d), o_fc[d],   m_fc[d]);
    if (rst_n && !m_act[d] && !o_empty[d]) begin
      m_act[d] = 1; m_anchor[d] = cyc + 1;
      if (d == 0) begin
        if (mq0.size() > 0) m_byte[d] = mq0.pop_front(); else m_byte[d] = 'x;
      end else begin
        if (mq1.size() > 0) m_byte[d] = mq1.pop_front(); else m_byte[d] = 'x;
      end
    end
  endtask

  always @(negedge clk) begin
    o_txd[0] = bus0.txd; o_rd[0] = bus0.fifo_rd_en; o_busy[0] = bus0.busy;
    o_done[0] = bus0.tx_done; o_fc[0] = bus0.frame_count; o_empty[0] = bus0.fifo_empty;
    o_txd[1] = bus1.txd; o_rd[1] = bus1.fifo_rd_en; o_busy[1] = bus1.busy;
    o_done[1] = bus1.tx_done; o_fc[1] = bus1.frame_count; o_empty[1] = bus1.fifo_empty;
    for (int d = 0; d < 2; d++) begin
      decode(d);
      step(d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int d, input int max_cyc, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(m_act[d] == 0 && o_empty[d] && (d == 0 ? mq0.size() : mq1.size()) == 0) && n < max_cyc);
    n_checks++;
    if (n >= max_cyc) begin
      n_err++;
      $display("FAIL %s: timeout after %0d cycles, required completion", name, n);
    end
    repeat (20) tick();
  endtask

  function automatic logic [31:0] rxb(input int d, input int i);
    if (d == 0) return (i < rx0.size()) ? 32'(rx0[i]) : 32'hFFFF_FFFF;
    else        return (i < rx1.size()) ? 32'(rx1[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0_snap, busy_snap, low_snap, n;
    bus0.fifo_dout = '0; bus0.fifo_empty = 1'b1;
    bus1.fifo_dout = '0; bus1.fifo_empty = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk); #1;
    chk("reset_txd",   bus0.txd,         1'b1);
    chk("reset_rd_en", bus0.fifo_rd_en,  1'b0);
    chk("reset_busy",  bus0.busy,        1'b0);
    chk("reset_fc",    bus0.frame_count, 16'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // single byte 0xA5
    push(0, 8'hA5);
    wait_idle(0, 400, "t1_wait");
    chk("t1_rx_count", rx0.size(), 1);
    chk("t1_rx_byte",  rxb(0, 0), 8'hA5);
    chk("t1_fc",       bus0.frame_count, 16'd1);
    chk("t1_model_fc", m_fc[0], 16'd1);
    chk("t1_rd_pulses", rd_cnt[0], 1);
    chk("t1_done_pulses", done_cnt[0], 1);
    chk("t1_low_cycles", low_cnt[0], 16 + 4 * 16);

    // three bytes back-to-back
    rx0.delete(); gq.delete();
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    wait_idle(0, 1000, "t2_wait");
    chk("t2_rx_count", rx0.size(), 3);
    chk("t2_rx_byte0", rxb(0, 0), 8'h00);
    chk("t2_rx_byte1", rxb(0, 1), 8'hFF);
    chk("t2_rx_byte2", rxb(0, 2), 8'h55);
    chk("t2_gap_count", gq.size(), 3);
    chk("t2_gap1", (gq.size() > 1) ? gq[1] : -1, 3);
    chk("t2_gap2", (gq.size() > 2) ? gq[2] : -1, 3);
    chk("t2_fc", bus0.frame_count, 16'd4);
    chk("t2_rd_pulses", rd_cnt[0], 4);

    // empty FIFO for 1000 cycles
    rd0_snap = rd_cnt[0]; busy_snap = busy_cnt[0]; low_snap = low_cnt[0];
    repeat (1000) tick();
    chk("t3_rd_pulses", rd_cnt[0] - rd0_snap, 0);
    chk("t3_busy_cycles", busy_cnt[0] - busy_snap, 0);
    chk("t3_low_cycles", low_cnt[0] - low_snap, 0);

    // reset during 4th data bit of 0x3C, then 0x81 goes out cleanly
    rx0.delete();
    rd0_snap = rd_cnt[0];
    push(0, 8'h3C); push(0, 8'h81);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(m_act[0] && (cyc - m_anchor[0]) == 70) && n < 300);
    chk("t4_reach_bit3", n < 300, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_txd_now",  bus0.txd,         1'b1);
    chk("t4_busy_now", bus0.busy,        1'b0);
    chk("t4_fc_now",   bus0.frame_count, 16'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle(0, 600, "t4_wait");
    chk("t4_rx_count", rx0.size(), 1);
    chk("t4_rx_byte",  rxb(0, 0), 8'h81);
    chk("t4_fc",       bus0.frame_count, 16'd1);
    chk("t4_rd_pulses", rd_cnt[0] - rd0_snap, 2);

    // frame_count wrap
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc[0] = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("t5_preload", bus0.frame_count, 16'hFFFF);
    push(0, 8'h5A);
    wait_idle(0, 400, "t5_wait");
    chk("t5_fc_wrap", bus0.frame_count, 16'h0000);

    // two stop bits on dut2
    rx1.delete();
    push(1, 8'h01);
    wait_idle(1, 400, "t6_wait");
    chk("t6_rx_count", rx1.size(), 1);
    chk("t6_rx_byte",  rxb(1, 0), 8'h01);
    chk("t6_done_after_last_bit", done_gap[1], 32);
    chk("t6_fc", bus1.frame_count, 16'd1);
    chk("t6_done_pulses", done_cnt[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, meaning input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, meaning serial bit rate; BIT_DIV = CLK_FREQ/BAUD, integer-truncated, elaboration error if < 2.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-004 Port: uart_tx_clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: fifo_dout  input  8  read data from a standard-mode (non-FWFT) FIFO, valid one cycle after fifo_rd_en.
REQ-007 Port: fifo_empty  input  1  FIFO empty flag.
REQ-008 Port: fifo_rd_en  output  1  one-cycle read strobe to the FIFO.
REQ-009 Port: txd  output  1  UART serial line, 8N1 or 8N2, LSB first, idle high.
REQ-010 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-011 Port: tx_done  output  1  one-cycle pulse at the end of the last stop bit.
REQ-012 Port: frame_count  output  16  count of completed frames.

Function
REQ-013 FSM states: IDLE, READ, LOAD, START, DATA, STOP.
REQ-014 IDLE: when fifo_empty = 0, drive fifo_rd_en = 1 for exactly one cycle and go to READ; otherwise stay in IDLE with txd = 1.
REQ-015 READ: one wait cycle for FIFO read latency; fifo_rd_en = 0; go to LOAD.
REQ-016 LOAD: latch fifo_dout into the 8-bit shift register, clear the baud counter, go to START.
REQ-017 START: txd = 0 for exactly BIT_DIV cycles, then go to DATA with bit index 0.
REQ-018 DATA: txd = shift[0] for BIT_DIV cycles per bit, right-shift after each bit, 8 bits, then go to STOP.
REQ-019 STOP: txd = 1 for STOP_BITS*BIT_DIV cycles; in the last cycle pulse tx_done, increment frame_count, go to IDLE.
REQ-020 Baud counter: counts 0..BIT_DIV-1, wraps to 0, width $clog2(BIT_DIV); bit boundaries occur only at wrap.
REQ-021 Back-to-back: if the FIFO is non-empty on return to IDLE, the next fifo_rd_en is asserted in that IDLE cycle, giving 3 cycles of idle-high between stop end and next start bit.
REQ-022 fifo_rd_en is never asserted while fifo_empty = 1, nor in any state other than IDLE.
REQ-023 fifo_empty changes during START/DATA/STOP are ignored; a frame in progress always completes.
REQ-024 frame_count wraps 0xFFFF -> 0x0000 without saturation or flag.
REQ-025 fifo_dout is sampled only in LOAD; txd is registered (glitch-free, no combinational path from inputs).

Reset
REQ-026 Reset low asynchronously forces: state IDLE, txd = 1, fifo_rd_en = 0, busy = 0, tx_done = 0, frame_count = 0, shift register = 0, baud counter = 0, bit index = 0.
REQ-027 Reset mid-frame aborts the frame immediately (txd = 1); the byte is lost, frame_count is not incremented, and the FIFO is not re-read for it.
REQ-028 After reset release, the first fifo_rd_en occurs no earlier than the first rising edge of uart_tx_clk with reset high.

Structure
REQ-029 A shared package uart_pkg holds the state enum encoding, the BIT_DIV computation function, and the constants DATA_BITS = 8 and IDLE_LEVEL = 1.
REQ-030 One sub-module, uart_baud_gen (counter plus wrap-tick output), is instantiated; everything else is flat.

Verification (use CLK_FREQ=16, BAUD=1, so BIT_DIV=16)
REQ-031 Single byte 0xA5 in the FIFO -> fifo_rd_en pulses once; txd is low for 16 cycles, then carries 1,0,1,0,0,1,0,1 at 16 cycles each, then is high for 16; tx_done pulses once; frame_count = 1.
REQ-032 Three bytes 0x00, 0xFF, 0x55 queued -> three frames decoded in order, with exactly 3 idle cycles between stop end and next start; frame_count = 3; fifo_rd_en pulses 3 times.
REQ-033 FIFO empty throughout -> txd stays 1, fifo_rd_en stays 0, and busy stays 0 for 1000 cycles.
REQ-034 Reset asserted in the 4th data bit of 0x3C -> txd = 1 immediately; frame_count = 0; the next queued byte 0x81 transmits cleanly after release.
REQ-035 STOP_BITS=2 with byte 0x01 -> stop high for 32 cycles, and tx_done is 32 cycles after the last data-bit boundary.
REQ-036 Preload frame_count to 0xFFFF via 65535 frames (or a forced state) and send one more byte -> frame_count = 0x0000.
